// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel deserializer.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } s2p_state_t;

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: MSB-first shift register feeding a
// parallel output register, so assembly of the next word overlaps a stalled output.
module s2p
  import s2p_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sdata,
  input  logic         svalid,
  output logic         sready,
  output logic [N-1:0] pdata,
  output logic         pvalid,
  input  logic         pready
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  s2p_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  pdata_q, pdata_d;
  logic          pvalid_q, pvalid_d;
  logic [N-1:0]  sh_next;
  logic          out_free;

  // Registered-state decode only, so the serial handshake has no combinational path.
  assign sready   = (state_q != HOLD);
  assign pdata    = pdata_q;
  assign pvalid   = pvalid_q;
  assign out_free = !pvalid_q || pready;
  assign sh_next  = {sh_q[N-2:0], sdata};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;

    // Drain first; a word landing in the same cycle overrides it with no bubble.
    if (pvalid_q && pready) pvalid_d = 1'b0;

    case (state_q)
      HOLD: begin
        if (pvalid_q && pready) begin
          pdata_d  = sh_q;
          pvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        if (svalid) begin
          sh_d = sh_next;
          if (cnt_q == CNT_LAST) begin
            if (out_free) begin
              pdata_d  = sh_next;
              pvalid_d = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d   = CNT_FULL;
              state_d = HOLD;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
    end
  end

endmodule

// File: tb/tb_s2p.sv
// Bench for s2p (N=4): directed scenarios plus a randomized run against a word-queue model.
module tb_s2p;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sdata = 1'b0;
  logic         svalid = 1'b0;
  logic         sready;
  logic [N-1:0] pdata;
  logic         pvalid;
  logic         pready = 1'b0;

  int checks = 0;
  int errors = 0;

  s2p #(.N(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sdata  (sdata),
    .svalid (svalid),
    .sready (sready),
    .pdata  (pdata),
    .pvalid (pvalid),
    .pready (pready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn   = 1'b0;
    svalid = 1'b0;
    sdata  = 1'b0;
    pready = 1'b0;
    step();
    step();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pvalid, pdata, sready} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: pvalid=%b pdata=%0d sready=%b, want 0 0 1", pvalid, pdata, sready);
    end
    for (int i = 0; i < 5; i++) begin
      svalid = 1'b0;
      sdata  = i[0];
      step();
      checks++;
      if ({pvalid, pdata, sready} !== {1'b0, 4'd0, 1'b1}) begin
        errors++;
        $display("FAIL idle_toggle[%0d]: pvalid=%b pdata=%0d sready=%b, want 0 0 1", i, pvalid, pdata, sready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    w = 4'b1001;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      svalid = 1'b1;
      sdata  = w[3-i];
      step();
      if (i < 3) begin
        checks++;
        if (pvalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_early[%0d]: pvalid=%b want 0", i, pvalid);
        end
      end
    end
    svalid = 1'b0;
    checks++;
    if ({pvalid, pdata} !== {1'b1, 4'd9}) begin
      errors++;
      $display("FAIL b2b_word: pvalid=%b pdata=%0d, want 1 9", pvalid, pdata);
    end
    step();
    checks++;
    if (pvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse_len: pvalid=%b want 0", pvalid);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] w;
    w = 4'b0001;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      svalid = 1'b1;
      sdata  = w[3-i];
      step();
      svalid = 1'b0;
      sdata  = ~sdata;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          step();
          checks++;
          if (pvalid !== 1'b0) begin
            errors++;
            $display("FAIL gap_early[%0d.%0d]: pvalid=%b want 0", i, g, pvalid);
          end
        end
      end
    end
    checks++;
    if ({pvalid, pdata} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL gap_word: pvalid=%b pdata=%0d, want 1 1", pvalid, pdata);
    end
    step();
    checks++;
    if ({pvalid, pdata} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL gap_pulse_len: pvalid=%b pdata=%0d, want 0 1", pvalid, pdata);
    end
  endtask

  task automatic test_stall_hold();
    logic [7:0] w;
    w = 8'b1001_1100;
    pready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1;
      sdata  = w[7-i];
      step();
      if (i == 3) begin
        checks++;
        if ({pvalid, pdata, sready} !== {1'b1, 4'd9, 1'b1}) begin
          errors++;
          $display("FAIL stall_first: pvalid=%b pdata=%0d sready=%b, want 1 9 1", pvalid, pdata, sready);
        end
      end
    end
    svalid = 1'b0;
    checks++;
    if ({pvalid, pdata, sready} !== {1'b1, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL stall_hold: pvalid=%b pdata=%0d sready=%b, want 1 9 0", pvalid, pdata, sready);
    end
    step();
    checks++;
    if ({pvalid, pdata, sready} !== {1'b1, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL stall_keep: pvalid=%b pdata=%0d sready=%b, want 1 9 0", pvalid, pdata, sready);
    end
    pready = 1'b1;
    step();
    checks++;
    if ({pvalid, pdata, sready} !== {1'b1, 4'd12, 1'b1}) begin
      errors++;
      $display("FAIL stall_release: pvalid=%b pdata=%0d sready=%b, want 1 12 1", pvalid, pdata, sready);
    end
    step();
    checks++;
    if ({pvalid, pdata} !== {1'b0, 4'd12}) begin
      errors++;
      $display("FAIL stall_drain: pvalid=%b pdata=%0d, want 0 12", pvalid, pdata);
    end
  endtask

  task automatic test_stream();
    logic [7:0] w;
    w = 8'b1111_0111;
    pready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1;
      sdata  = w[7-i];
      checks++;
      if (sready !== 1'b1) begin
        errors++;
        $display("FAIL stream_sready[%0d]: sready=%b want 1", i, sready);
      end
      step();
      checks++;
      if (i == 3) begin
        if ({pvalid, pdata} !== {1'b1, 4'd15}) begin
          errors++;
          $display("FAIL stream_w0: pvalid=%b pdata=%0d, want 1 15", pvalid, pdata);
        end
      end else if (i == 7) begin
        if ({pvalid, pdata} !== {1'b1, 4'd7}) begin
          errors++;
          $display("FAIL stream_w1: pvalid=%b pdata=%0d, want 1 7", pvalid, pdata);
        end
      end else if (pvalid !== 1'b0) begin
        errors++;
        $display("FAIL stream_gap[%0d]: pvalid=%b want 0", i, pvalid);
      end
    end
    svalid = 1'b0;
    step();
  endtask

  task automatic test_reset_midword();
    logic [3:0] w;
    pready = 1'b1;
    w = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      svalid = 1'b1;
      sdata  = w[3-i];
      step();
    end
    svalid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({pvalid, pdata, sready} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: pvalid=%b pdata=%0d sready=%b, want 0 0 1", pvalid, pdata, sready);
    end
    step();
    checks++;
    if ({pvalid, pdata, sready} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_held: pvalid=%b pdata=%0d sready=%b, want 0 0 1", pvalid, pdata, sready);
    end
    @(negedge clk);
    rstn = 1'b1;
    w = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      svalid = 1'b1;
      sdata  = w[3-i];
      step();
      if (i < 3) begin
        checks++;
        if (pvalid !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_early[%0d]: pvalid=%b want 0", i, pvalid);
        end
      end
    end
    svalid = 1'b0;
    checks++;
    if ({pvalid, pdata} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL post_reset_word: pvalid=%b pdata=%0d, want 1 5", pvalid, pdata);
    end
    step();
  endtask

  // Model: accepted bits collect in a list; each N bits form a word queued for delivery.
  // At most two finished words can be buffered, so the serial side stalls at two.
  task automatic test_random();
    bit         bits[$];
    int         words[$];
    int         last_word;
    int         w;
    bit         acc, drn;
    logic [N-1:0] exp_pdata;
    logic         exp_pvalid, exp_sready;
    do_reset();
    last_word = 0;
    for (int c = 0; c < 800; c++) begin
      svalid = ($urandom_range(0, 3) != 0);
      sdata  = $urandom_range(0, 1);
      pready = ($urandom_range(0, 2) != 0) ^ (c[7]);
      acc = svalid && (words.size() < 2);
      drn = pready && (words.size() > 0);
      step();
      if (drn) last_word = words.pop_front();
      if (acc) begin
        bits.push_back(sdata);
        if (bits.size() == N) begin
          w = 0;
          foreach (bits[k]) w = w * 2 + int'(bits[k]);
          words.push_back(w);
          bits.delete();
        end
      end
      exp_pvalid = (words.size() > 0);
      exp_sready = (words.size() < 2);
      exp_pdata  = (words.size() > 0) ? N'(words[0]) : N'(last_word);
      checks++;
      if ({pvalid, pdata, sready} !== {exp_pvalid, exp_pdata, exp_sready}) begin
        errors++;
        $display("FAIL random[%0d]: pvalid=%b pdata=%0d sready=%b, want %b %0d %b",
                 c, pvalid, pdata, sready, exp_pvalid, exp_pdata, exp_sready);
      end
    end
    svalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_stall_hold();
    test_stream();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
